// File: rtl/fractal_sync_nary_if.sv
// fractal_sync_nary_if: child/parent barrier signals of one fractal sync node
interface fractal_sync_nary_if #(
  parameter int unsigned SLV_PORTS = 4,
  parameter int unsigned LVL_WIDTH = 3
);
  localparam int unsigned MW = LVL_WIDTH > 1 ? LVL_WIDTH - 1 : 1;
  logic [SLV_PORTS-1:0] slv_sync_i;
  logic [SLV_PORTS-1:0][LVL_WIDTH-1:0] slv_level_i;
  logic [SLV_PORTS-1:0] slv_ack_i;
  logic slv_wake_o;
  logic slv_error_o;
  logic mst_sync_o;
  logic [MW-1:0] mst_level_o;
  logic mst_ack_o;
  logic mst_wake_i;
  logic mst_error_i;
  modport slave (
    input  slv_sync_i, slv_level_i, slv_ack_i, mst_wake_i, mst_error_i,
    output slv_wake_o, slv_error_o, mst_sync_o, mst_level_o, mst_ack_o
  );
  modport master (
    output slv_sync_i, slv_level_i, slv_ack_i, mst_wake_i, mst_error_i,
    input  slv_wake_o, slv_error_o, mst_sync_o, mst_level_o, mst_ack_o
  );
endinterface

// File: rtl/fractal_sync_nary.sv
// fractal_sync_nary: n-ary barrier node that resolves locally or forwards upward, with arrival timeout
module fractal_sync_nary #(
  parameter int unsigned SLV_PORTS = 4,
  parameter int unsigned LVL_WIDTH = 3,
  parameter int unsigned TIMEOUT   = 0
) (
  input logic clk_i,
  input logic rst_i,
  fractal_sync_nary_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PROPAGATE, SYNC} state_e;
  state_e state_q;
  logic [SLV_PORTS-1:0] sync_q, ack_q;
  logic [SLV_PORTS-1:0][LVL_WIDTH-1:0] level_q;
  logic err_q, prop_q, mst_sync_q;
  logic valid, is_local, done, timeout, partial;
  if (SLV_PORTS < 2 || LVL_WIDTH < 1) begin : g_bad_param
    $fatal(1, "fractal_sync_nary: SLV_PORTS must be >= 2 and LVL_WIDTH >= 1");
  end
  always_comb begin
    valid = 1'b1;
    for (int i = 0; i < SLV_PORTS; i++)
      for (int j = 0; j < SLV_PORTS; j++)
        if (sync_q[i] && sync_q[j] && level_q[i] != level_q[j]) valid = 1'b0;
  end
  assign is_local = (LVL_WIDTH == 1) || level_q[0][0];
  assign done     = ((ack_q | bus.slv_ack_i) & sync_q) == sync_q;
  assign partial  = state_q == IDLE && |sync_q && !(&sync_q);
  if (TIMEOUT > 0) begin : g_timeout
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q;
    always_ff @(posedge clk_i) cnt_q <= (rst_i || !partial) ? '0 : cnt_q + 1'b1;
    assign timeout = partial && cnt_q == CW'(TIMEOUT - 1);
  end else begin : g_no_timeout
    assign timeout = 1'b0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      ack_q      <= '0;
      level_q    <= '0;
      err_q      <= 1'b0;
      prop_q     <= 1'b0;
      mst_sync_q <= 1'b0;
    end else begin
      mst_sync_q <= 1'b0;
      case (state_q)
        IDLE: begin
          for (int i = 0; i < SLV_PORTS; i++)
            if (bus.slv_sync_i[i] && !sync_q[i]) begin
              sync_q[i]  <= 1'b1;
              level_q[i] <= bus.slv_level_i[i];
            end
          if (&sync_q) begin
            state_q    <= (is_local || !valid) ? SYNC : PROPAGATE;
            err_q      <= !valid;
            prop_q     <= !is_local && valid;
            mst_sync_q <= !is_local && valid;
          end else if (timeout) begin
            state_q <= SYNC;
            err_q   <= 1'b1;
            prop_q  <= 1'b0;
          end
        end
        PROPAGATE: if (bus.mst_wake_i) begin
          state_q <= SYNC;
          err_q   <= err_q | bus.mst_error_i;
        end
        SYNC: begin
          ack_q <= ack_q | bus.slv_ack_i;
          if (done) begin
            state_q <= IDLE;
            sync_q  <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            prop_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.slv_wake_o  = state_q == SYNC;
  assign bus.slv_error_o = state_q == SYNC && err_q;
  assign bus.mst_sync_o  = mst_sync_q;
  assign bus.mst_ack_o   = state_q == SYNC && done && prop_q;
  if (LVL_WIDTH > 1) begin : g_lvl
    assign bus.mst_level_o = level_q[0][LVL_WIDTH-1:1];
  end else begin : g_no_lvl
    assign bus.mst_level_o = '0;
  end
endmodule

// File: tb/tb_fractal_sync_nary.sv
// tb_fractal_sync_nary: directed scoreboard bench for the n-ary fractal sync node
module tb_fractal_sync_nary;
  localparam int N = 4;
  localparam int W = 3;
  typedef enum int {MSYNC, WAKE, MACK, WFALL} kind_e;
  typedef struct {kind_e kind; int data; int cyc;} ev_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wake_prev = 1'b0;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  ev_t exp_q[$];
  fractal_sync_nary_if #(.SLV_PORTS(N), .LVL_WIDTH(W)) bus ();
  fractal_sync_nary #(.SLV_PORTS(N), .LVL_WIDTH(W), .TIMEOUT(8)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic expect_ev(input kind_e k, input int d, input int c);
    ev_t e;
    e.kind = k;
    e.data = d;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask
  task automatic observe(input kind_e k, input int d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_%s: got data=%0d at cycle %0d, expected no event", k.name(), d, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.data != d || e.cyc != cyc) begin
        failures++;
        $display("FAIL event_%s: got %s data=%0d cycle=%0d, expected %s data=%0d cycle=%0d",
                 e.kind.name(), k.name(), d, cyc, e.kind.name(), e.data, e.cyc);
      end
    end
  endtask
  task automatic check_idle(input string name);
    logic [5:0] v;
    v = {bus.slv_wake_o, bus.slv_error_o, bus.mst_sync_o, bus.mst_level_o, bus.mst_ack_o};
    checks++;
    if (v !== 6'b0) begin
      failures++;
      $display("FAIL %s: outputs=%b, expected 000000", name, v);
    end
  endtask
  task automatic pulse_sync(input logic [N-1:0] m, input logic [N-1:0][W-1:0] lv);
    bus.slv_sync_i  = m;
    bus.slv_level_i = lv;
    step(1);
    bus.slv_sync_i = '0;
  endtask
  task automatic pulse_ack(input logic [N-1:0] m);
    bus.slv_ack_i = m;
    step(1);
    bus.slv_ack_i = '0;
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mst_sync_o) observe(MSYNC, int'(bus.mst_level_o));
      if (bus.slv_wake_o && !wake_prev) observe(WAKE, int'(bus.slv_error_o));
      if (bus.mst_ack_o) observe(MACK, 0);
      if (!bus.slv_wake_o && wake_prev) observe(WFALL, 0);
    end
    wake_prev <= bus.slv_wake_o;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end
  initial begin
    int t;
    bus.slv_sync_i  = '0;
    bus.slv_ack_i   = '0;
    bus.slv_level_i = '0;
    bus.mst_wake_i  = 1'b0;
    bus.mst_error_i = 1'b0;
    step(3);
    @(negedge clk);
    check_idle("reset_outputs");
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1);
    // local barrier, all arrive together
    t = cyc;
    expect_ev(WAKE, 0, t + 2);
    pulse_sync(4'hF, {4{3'b001}});
    step(2);
    expect_ev(WFALL, 0, cyc + 1);
    pulse_ack(4'hF);
    step(2);
    // propagated barrier, staggered arrivals, parent returns an error
    pulse_sync(4'h1, {4{3'b110}});
    step(1);
    pulse_sync(4'h6, {4{3'b110}});
    t = cyc;
    expect_ev(MSYNC, 3, t + 2);
    pulse_sync(4'h8, {4{3'b110}});
    step(4);
    expect_ev(WAKE, 1, t + 6);
    bus.mst_wake_i  = 1'b1;
    bus.mst_error_i = 1'b1;
    step(1);
    bus.mst_wake_i  = 1'b0;
    bus.mst_error_i = 1'b0;
    pulse_ack(4'h3);
    expect_ev(MACK, 0, cyc);
    expect_ev(WFALL, 0, cyc + 1);
    pulse_ack(4'hC);
    step(2);
    // level mismatch, acked on first wake cycle
    t = cyc;
    expect_ev(WAKE, 1, t + 2);
    pulse_sync(4'hF, {3'b100, 3'b010, 3'b010, 3'b010});
    step(1);
    expect_ev(WFALL, 0, cyc + 1);
    pulse_ack(4'hF);
    // timeout right after the previous barrier frees up
    t = cyc;
    expect_ev(WAKE, 1, t + 9);
    pulse_sync(4'h3, {4{3'b001}});
    step(8);
    pulse_ack(4'h4);
    expect_ev(WFALL, 0, cyc + 1);
    pulse_ack(4'h3);
    step(2);
    // duplicate sync keeps first level; late sync during SYNC is dropped
    pulse_sync(4'h1, {4{3'b001}});
    pulse_sync(4'h1, {4{3'b011}});
    t = cyc;
    expect_ev(WAKE, 0, t + 2);
    pulse_sync(4'hE, {4{3'b001}});
    step(1);
    pulse_sync(4'h2, {4{3'b001}});
    expect_ev(WFALL, 0, cyc + 1);
    pulse_ack(4'hF);
    pulse_sync(4'hD, {4{3'b001}});
    step(1);
    expect_ev(WAKE, 0, cyc + 2);
    pulse_sync(4'h2, {4{3'b001}});
    step(1);
    expect_ev(WFALL, 0, cyc + 1);
    pulse_ack(4'hF);
    step(2);
    // reset while propagating, then a fresh barrier with wake coincident to mst_sync
    t = cyc;
    expect_ev(MSYNC, 3, t + 2);
    pulse_sync(4'hF, {4{3'b110}});
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    check_idle("after_mid_reset");
    t = cyc;
    expect_ev(MSYNC, 3, t + 2);
    pulse_sync(4'hF, {4{3'b110}});
    step(1);
    expect_ev(WAKE, 0, t + 3);
    bus.mst_wake_i = 1'b1;
    step(1);
    bus.mst_wake_i = 1'b0;
    expect_ev(MACK, 0, cyc);
    expect_ev(WFALL, 0, cyc + 1);
    pulse_ack(4'hF);
    step(3);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_events: %0d still queued, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
